adder_controller: RTL and testbench

Sequencer that drives `potential_adder` from the neuron-integration side. It programs the six model parameters (A, B, C, D, VT, U) through the `load`/`init_mode` port, then runs one integration step per request. Each step is a one-cycle `time_step` pulse followed by a wait for `done`. It returns the captured potential and spike to the requester with a valid/ack handshake, a timeout error and a running spike count.

---
 rtl/adder_controller.sv | 248 ++++++++++++++++++++++++
 tb/tb_adder_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_controller.sv
// adder_controller: sequences parameter loads and integration steps for potential_adder.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for cfg_start (priority) or step_req
// CFG_LOAD   | present one parameter to the adder (load=1, init_mode=idx)
// CFG_GAP    | one cycle with load low between parameters
// CFG_END    | return init_mode to 000, pulse cfg_done
// STEP       | issue the single time_step pulse, arm the timeout counter
// WAIT       | wait for a rising edge of done or timeout expiry
// RESULT     | pulse res_valid, update spike_count
//
// Every output is a register. Each output's next value is computed from the
// current state, so it appears one cycle after the state that produces it.
module adder_controller #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic [WIDTH-1:0] cfg_a,
    input  logic [WIDTH-1:0] cfg_b,
    input  logic [WIDTH-1:0] cfg_c,
    input  logic [WIDTH-1:0] cfg_d,
    input  logic [WIDTH-1:0] cfg_vt,
    input  logic [WIDTH-1:0] cfg_u,
    output logic             cfg_busy,
    output logic             cfg_done,
    input  logic             step_req,
    input  logic [WIDTH-1:0] step_weight,
    input  logic [WIDTH-1:0] step_decayed,
    input  logic [1:0]       step_model,
    output logic             step_ack,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_potential,
    output logic             res_spike,
    output logic             res_timeout,
    output logic [CNT_W-1:0] spike_count,
    output logic             load,
    output logic [2:0]       init_mode,
    output logic [WIDTH-1:0] input_weight,
    output logic [WIDTH-1:0] decayed_potential,
    output logic [1:0]       model,
    output logic             time_step,
    input  logic             done,
    input  logic             spike,
    input  logic [WIDTH-1:0] final_potential
);

    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CFG_LOAD,
        CFG_GAP,
        CFG_END,
        STEP,
        WAIT,
        RESULT
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         idx, idx_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic               done_q;
    logic [WIDTH-1:0]   par_a, par_b, par_c, par_d, par_vt, par_u;
    logic [WIDTH-1:0]   par_sel;

    logic               load_nxt;
    logic [2:0]         init_mode_nxt;
    logic [WIDTH-1:0]   input_weight_nxt;
    logic [WIDTH-1:0]   decayed_potential_nxt;
    logic [1:0]         model_nxt;
    logic               time_step_nxt;
    logic               cfg_busy_nxt;
    logic               cfg_done_nxt;
    logic               step_ack_nxt;
    logic               res_valid_nxt;
    logic [WIDTH-1:0]   res_potential_nxt;
    logic               res_spike_nxt;
    logic               res_timeout_nxt;
    logic [CNT_W-1:0]   spike_count_nxt;

    // Select the latched parameter addressed by the load index (1=A .. 6=U).
    always_comb begin
        par_sel = '0;
        case (idx)
            3'd1:    par_sel = par_a;
            3'd2:    par_sel = par_b;
            3'd3:    par_sel = par_c;
            3'd4:    par_sel = par_d;
            3'd5:    par_sel = par_vt;
            3'd6:    par_sel = par_u;
            default: par_sel = '0;
        endcase
    end

    // Next-state and next-output logic; pulses default low, data outputs hold.
    always_comb begin
        state_nxt             = state;
        idx_nxt               = idx;
        tmr_nxt               = tmr;
        load_nxt              = 1'b0;
        time_step_nxt         = 1'b0;
        cfg_busy_nxt          = 1'b0;
        cfg_done_nxt          = 1'b0;
        step_ack_nxt          = 1'b0;
        res_valid_nxt         = 1'b0;
        init_mode_nxt         = init_mode;
        input_weight_nxt      = input_weight;
        decayed_potential_nxt = decayed_potential;
        model_nxt             = model;
        res_potential_nxt     = res_potential;
        res_spike_nxt         = res_spike;
        res_timeout_nxt       = res_timeout;
        spike_count_nxt       = spike_count;

        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_nxt    = CFG_LOAD;
                    idx_nxt      = 3'd1;
                    cfg_busy_nxt = 1'b1;
                end else if (step_req) begin
                    state_nxt             = STEP;
                    step_ack_nxt          = 1'b1;
                    input_weight_nxt      = step_weight;
                    decayed_potential_nxt = step_decayed;
                    model_nxt             = step_model;
                end
            end
            CFG_LOAD: begin
                load_nxt         = 1'b1;
                init_mode_nxt    = idx;
                input_weight_nxt = par_sel;
                cfg_busy_nxt     = 1'b1;
                state_nxt        = CFG_GAP;
            end
            CFG_GAP: begin
                cfg_busy_nxt = 1'b1;
                if (idx < 3'd6) begin
                    idx_nxt   = idx + 3'd1;
                    state_nxt = CFG_LOAD;
                end else begin
                    state_nxt = CFG_END;
                end
            end
            CFG_END: begin
                cfg_busy_nxt  = 1'b1;
                cfg_done_nxt  = 1'b1;
                init_mode_nxt = 3'd0;
                idx_nxt       = 3'd0;
                state_nxt     = IDLE;
            end
            STEP: begin
                time_step_nxt = 1'b1;
                tmr_nxt       = TMR_W'(TIMEOUT);
                state_nxt     = WAIT;
            end
            WAIT: begin
                // Only a fresh rising edge counts; a done level held over
                // from the previous step must not complete this one.
                if (done && !done_q) begin
                    res_potential_nxt = final_potential;
                    res_spike_nxt     = spike;
                    res_timeout_nxt   = 1'b0;
                    state_nxt         = RESULT;
                end else if (tmr == '0) begin
                    res_spike_nxt   = 1'b0;
                    res_timeout_nxt = 1'b1;
                    state_nxt       = RESULT;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            RESULT: begin
                res_valid_nxt = 1'b1;
                if (res_spike) begin
                    spike_count_nxt = spike_count + CNT_W'(1);
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, parameter latches and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            idx               <= 3'd0;
            tmr               <= '0;
            done_q            <= 1'b0;
            par_a             <= '0;
            par_b             <= '0;
            par_c             <= '0;
            par_d             <= '0;
            par_vt            <= '0;
            par_u             <= '0;
            load              <= 1'b0;
            init_mode         <= 3'd0;
            input_weight      <= '0;
            decayed_potential <= '0;
            model             <= 2'd0;
            time_step         <= 1'b0;
            cfg_busy          <= 1'b0;
            cfg_done          <= 1'b0;
            step_ack          <= 1'b0;
            res_valid         <= 1'b0;
            res_potential     <= '0;
            res_spike         <= 1'b0;
            res_timeout       <= 1'b0;
            spike_count       <= '0;
        end else begin
            state             <= state_nxt;
            idx               <= idx_nxt;
            tmr               <= tmr_nxt;
            done_q            <= done;
            if (state == IDLE && cfg_start) begin
                par_a  <= cfg_a;
                par_b  <= cfg_b;
                par_c  <= cfg_c;
                par_d  <= cfg_d;
                par_vt <= cfg_vt;
                par_u  <= cfg_u;
            end
            load              <= load_nxt;
            init_mode         <= init_mode_nxt;
            input_weight      <= input_weight_nxt;
            decayed_potential <= decayed_potential_nxt;
            model             <= model_nxt;
            time_step         <= time_step_nxt;
            cfg_busy          <= cfg_busy_nxt;
            cfg_done          <= cfg_done_nxt;
            step_ack          <= step_ack_nxt;
            res_valid         <= res_valid_nxt;
            res_potential     <= res_potential_nxt;
            res_spike         <= res_spike_nxt;
            res_timeout       <= res_timeout_nxt;
            spike_count       <= spike_count_nxt;
        end
    end

endmodule

// File: tb/tb_adder_controller.sv
// tb_adder_controller: directed and randomized checks of adder_controller against a stub adder.
module tb_adder_controller;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 1023;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_start = 1'b0;
    logic [WIDTH-1:0] cfg_a = '0, cfg_b = '0, cfg_c = '0, cfg_d = '0, cfg_vt = '0, cfg_u = '0;
    logic             cfg_busy, cfg_done;
    logic             step_req = 1'b0;
    logic [WIDTH-1:0] step_weight = '0, step_decayed = '0;
    logic [1:0]       step_model = 2'd0;
    logic             step_ack, res_valid, res_spike, res_timeout;
    logic [WIDTH-1:0] res_potential;
    logic [CNT_W-1:0] spike_count;
    logic             load, time_step;
    logic [2:0]       init_mode;
    logic [WIDTH-1:0] input_weight, decayed_potential;
    logic [1:0]       model;
    logic             done, spike;
    logic [WIDTH-1:0] final_potential;

    always #5 clk = ~clk;

    adder_controller #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_c(cfg_c),
        .cfg_d(cfg_d), .cfg_vt(cfg_vt), .cfg_u(cfg_u),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .step_req(step_req), .step_weight(step_weight), .step_decayed(step_decayed),
        .step_model(step_model), .step_ack(step_ack),
        .res_valid(res_valid), .res_potential(res_potential), .res_spike(res_spike),
        .res_timeout(res_timeout), .spike_count(spike_count),
        .load(load), .init_mode(init_mode), .input_weight(input_weight),
        .decayed_potential(decayed_potential), .model(model), .time_step(time_step),
        .done(done), .spike(spike), .final_potential(final_potential)
    );

    logic [124:0] outs;
    assign outs = {load, init_mode, input_weight, decayed_potential, model, time_step,
                   cfg_busy, cfg_done, step_ack, res_valid, res_potential, res_spike,
                   res_timeout, spike_count};

    // Stub adder: keeps VT from loads, raises done stub_n cycles after time_step.
    int               stub_n = 1;
    bit               stub_never = 1'b0;
    logic [WIDTH-1:0] stub_vt = '0;
    int               stub_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done            <= 1'b0;
            spike           <= 1'b0;
            final_potential <= '0;
            stub_cnt        <= 0;
        end else begin
            if (load && init_mode == 3'd5) stub_vt <= input_weight;
            if (time_step) begin
                done            <= 1'b0;
                final_potential <= input_weight + decayed_potential;
                spike           <= ((input_weight + decayed_potential) >= stub_vt);
                stub_cnt        <= stub_never ? 0 : stub_n;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) done <= 1'b1;
            end
        end
    end

    // Cycle counter and event recorder.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int               n_load = 0, n_ts = 0, n_ack = 0, n_rv = 0, n_cfgdone = 0, n_overlap = 0;
    int               ts_cyc = 0, done_rise_cyc = 0;
    logic [WIDTH-1:0] ts_w, ts_d;
    logic [1:0]       ts_m;
    logic             done_prev = 1'b0;
    logic [2:0]       load_mode[$];
    logic [WIDTH-1:0] load_w[$];
    int               load_cyc[$];
    always @(negedge clk) begin
        if (load) begin
            n_load++;
            load_mode.push_back(init_mode);
            load_w.push_back(input_weight);
            load_cyc.push_back(cyc);
        end
        if (time_step) begin
            n_ts++;
            ts_cyc = cyc;
            ts_w = input_weight;
            ts_d = decayed_potential;
            ts_m = model;
        end
        if (load && time_step) n_overlap++;
        if (step_ack) n_ack++;
        if (res_valid) n_rv++;
        if (cfg_done) n_cfgdone++;
        if (done && !done_prev) done_rise_cyc = cyc;
        done_prev = done;
    end

    int               tests = 0, fails = 0;
    logic [WIDTH-1:0] exp_pot = '0;
    int               exp_cnt = 0;
    logic [WIDTH-1:0] vt_cfg = '0;
    logic [WIDTH-1:0] cfg_vals[6];
    int               start_cyc = 0, cfg_done_cyc = 0, last_ack_cyc = 0, ack_snap = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_begin(input logic [WIDTH-1:0] a, b, c, d, vt, u, input bit with_req);
        @(negedge clk);
        cfg_a = a; cfg_b = b; cfg_c = c; cfg_d = d; cfg_vt = vt; cfg_u = u;
        cfg_vals[0] = a; cfg_vals[1] = b; cfg_vals[2] = c;
        cfg_vals[3] = d; cfg_vals[4] = vt; cfg_vals[5] = u;
        load_mode.delete(); load_w.delete(); load_cyc.delete();
        ack_snap = n_ack;
        cfg_start = 1'b1;
        if (with_req) step_req = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic cfg_check();
        for (int i = 0; i < 40 && !cfg_done; i++) @(negedge clk);
        chk("cfg_done_seen", cfg_done, 1);
        cfg_done_cyc = cyc;
        chk("cfg_done_time", cfg_done_cyc - start_cyc, 13);
        chk("cfg_init_mode_end", init_mode, 0);
        chk("cfg_busy_at_done", cfg_busy, 1);
        chk("cfg_load_count", load_mode.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("cfg_load_mode", load_mode[i], i + 1);
            chk("cfg_load_weight", load_w[i], cfg_vals[i]);
            chk("cfg_load_time", load_cyc[i] - start_cyc, 1 + 2 * i);
        end
        chk("cfg_no_ack_during", n_ack - ack_snap, 0);
        @(negedge clk);
        chk("cfg_busy_after", cfg_busy, 0);
        chk("cfg_done_pulse", cfg_done, 0);
    endtask

    task automatic run_step(input logic [WIDTH-1:0] w, d, input logic [1:0] m,
                            input int n, input bit never, input bit pre);
        int ack_c, rv_c, ts_snap;
        bit exp_spk;
        stub_n = n;
        stub_never = never;
        ts_snap = n_ts;
        if (!pre) begin
            @(negedge clk);
            step_weight = w; step_decayed = d; step_model = m; step_req = 1'b1;
        end
        for (int i = 0; i < 40 && !step_ack; i++) @(negedge clk);
        chk("step_ack_seen", step_ack, 1);
        ack_c = cyc;
        last_ack_cyc = ack_c;
        step_req = 1'b0;
        for (int i = 0; i < TIMEOUT + 50 && !res_valid; i++) @(negedge clk);
        chk("res_valid_seen", res_valid, 1);
        rv_c = cyc;
        if (never) begin
            exp_spk = 1'b0;
        end else begin
            exp_pot = w + d;
            exp_spk = ((w + d) >= vt_cfg);
        end
        if (exp_spk) exp_cnt++;
        chk("one_time_step", n_ts - ts_snap, 1);
        chk("ts_after_ack", ts_cyc - ack_c, 1);
        chk("ts_weight", ts_w, w);
        chk("ts_decayed", ts_d, d);
        chk("ts_model", ts_m, m);
        if (never) begin
            chk("timeout_latency", rv_c - ts_cyc, TIMEOUT + 2);
        end else begin
            chk("done_latency", rv_c - done_rise_cyc, 2);
            chk("min_latency", (rv_c - ack_c) >= 4, 1);
        end
        chk("res_potential", res_potential, exp_pot);
        chk("res_spike", res_spike, exp_spk);
        chk("res_timeout", res_timeout, never);
        chk("spike_count", spike_count, exp_cnt[CNT_W-1:0]);
        @(negedge clk);
        chk("res_valid_pulse", res_valid, 0);
    endtask

    initial begin
        int s_load, s_ts, s_cd, s_rv;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs, 0);
        rst_n = 1'b1;
        @(negedge clk);

        cfg_begin(10, 20, 30, 40, 50, 5, 1'b0);
        vt_cfg = 50;
        cfg_check();

        run_step(25, 25, 2'b00, 3, 1'b0, 1'b0);
        run_step(25, 35, 2'b01, 100, 1'b0, 1'b0);
        run_step(30, 10, 2'b10, 4, 1'b0, 1'b0);
        run_step(7, 8, 2'b00, 1, 1'b1, 1'b0);

        // cfg_start and step_req together: configuration first, then the step.
        step_weight = 20; step_decayed = 40; step_model = 2'b01;
        cfg_begin(10, 20, 30, 40, 50, 5, 1'b1);
        cfg_check();
        run_step(20, 40, 2'b01, 5, 1'b0, 1'b1);
        chk("ack_after_cfg", last_ack_cyc - cfg_done_cyc, 1);

        // Reset during the gap after the third parameter load.
        cfg_begin(1, 2, 3, 4, 999, 6, 1'b0);
        while (cyc < start_cyc + 6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_cfg_outputs", outs, 0);
        chk("rst_cfg_loads", load_mode.size(), 3);
        exp_cnt = 0;
        exp_pot = '0;
        repeat (3) @(negedge clk);
        s_load = n_load; s_ts = n_ts; s_cd = n_cfgdone;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_cfg_no_load", n_load - s_load, 0);
        chk("rst_cfg_no_done", n_cfgdone - s_cd, 0);
        chk("rst_cfg_no_ts", n_ts - s_ts, 0);
        run_step(10, 45, 2'b00, 2, 1'b0, 1'b0);

        // Reset while waiting on an adder that never answers.
        stub_never = 1'b1;
        @(negedge clk);
        step_weight = 9; step_decayed = 9; step_model = 2'b10; step_req = 1'b1;
        for (int i = 0; i < 40 && !step_ack; i++) @(negedge clk);
        chk("wait_ack_seen", step_ack, 1);
        step_req = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_wait_outputs", outs, 0);
        exp_cnt = 0;
        exp_pot = '0;
        repeat (3) @(negedge clk);
        s_ts = n_ts; s_rv = n_rv;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst_wait_no_ts", n_ts - s_ts, 0);
        chk("rst_wait_no_rv", n_rv - s_rv, 0);
        run_step(5, 5, 2'b01, 6, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            run_step(WIDTH'($urandom_range(0, 40)), WIDTH'($urandom_range(0, 40)),
                     2'($urandom_range(0, 2)), $urandom_range(1, 12), 1'b0, 1'b0);
        end

        chk("load_ts_exclusive", n_overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
